// File: rtl/mem_cmd_queue.sv
// In-order command FIFO in front of sram_cmd; issues one command per clock and
// returns read data as a one-cycle response. Optional bypass: MEM_CMD_QUEUE_BYPASS_EN.
module mem_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [12:0]            in_cmd,
  output logic [12:0]            cmd,
  input  logic [7:0]             rdata,
  output logic                   rsp_valid,
  output logic [3:0]             rsp_addr,
  output logic [7:0]             rsp_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
  } mem_cmd_t;

  mem_cmd_t          fifo [DEPTH];
  mem_cmd_t          in_c;
  mem_cmd_t          head_c;
  mem_cmd_t          cmd_q;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic              push;
  logic              pop;
  logic              byp;
  logic              store;
  logic              iss_rd;
  logic              pend_rd;
  logic [3:0]        pend_addr;

  assign in_c     = mem_cmd_t'(in_cmd);
  assign head_c   = fifo[rptr];
  assign cmd      = cmd_q;
  // Readiness looks only at the registered occupancy, never at a same-cycle pop.
  assign in_ready = (count < (PW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0);

`ifdef MEM_CMD_QUEUE_BYPASS_EN
  assign byp = push && (count == '0);
`else
  assign byp = 1'b0;
`endif

  assign store = push && !byp;

  // Storage array carries no reset; emptiness is defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (rst_n && store) begin
      fifo[wptr] <= in_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      cmd_q     <= '0;
      iss_rd    <= 1'b0;
      pend_rd   <= 1'b0;
      pend_addr <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
    end else begin
      if (store) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Issue stage: head of queue, bypassed input, or the idle command.
      if (pop) begin
        cmd_q  <= head_c;
        iss_rd <= !head_c.we;
      end else if (byp) begin
        cmd_q  <= in_c;
        iss_rd <= !in_c.we;
      end else begin
        cmd_q  <= '0;
        iss_rd <= 1'b0;
      end

      // SRAM sample stage: the command on cmd is consumed by sram_cmd here.
      pend_rd   <= iss_rd;
      pend_addr <= cmd_q.addr;

      // Response stage: rdata now holds the registered read result.
      rsp_valid <= pend_rd;
      rsp_addr  <= pend_addr;
      rsp_data  <= rdata;
    end
  end

endmodule
